// File: rtl/hilo_bank.sv
// Bank of PAIRS HI/LO register pairs with write, clear and 2W-bit accumulate ops.
// Latency: 2 cycles from issue to a visible commit, for every op type.
// Backpressure: none. One op is accepted per cycle. Reserved ops are dropped and flagged.
module hilo_bank #(
  parameter int DATA_W = 32,
  parameter int PAIRS  = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [2:0]        wr_op_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_hi_i,
  input  logic [DATA_W-1:0] wr_lo_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              rd_pending_o,
  output logic              acc_ovf_o,
  output logic              op_err_o
);

  localparam logic [2:0] OP_WR_BOTH = 3'b000;
  localparam logic [2:0] OP_WR_HI   = 3'b001;
  localparam logic [2:0] OP_WR_LO   = 3'b010;
  localparam logic [2:0] OP_ACC_ADD = 3'b011;
  localparam logic [2:0] OP_ACC_SUB = 3'b100;
  localparam logic [2:0] OP_CLEAR   = 3'b101;

  // Committed architectural state
  logic [DATA_W-1:0] r_hi [PAIRS];
  logic [DATA_W-1:0] r_lo [PAIRS];

  // Stage 1: accepted op and its operands
  logic              r_s1_vld;
  logic [2:0]        r_s1_op;
  logic [IDX_W-1:0]  r_s1_idx;
  logic [DATA_W-1:0] r_s1_hi;
  logic [DATA_W-1:0] r_s1_lo;

  // Stage 2: finished low half, carry/borrow, and what the high half needs
  logic              r_s2_vld;
  logic [2:0]        r_s2_op;
  logic [IDX_W-1:0]  r_s2_idx;
  logic [DATA_W-1:0] r_s2_lo;
  logic [DATA_W-1:0] r_s2_p_hi;
  logic [DATA_W-1:0] r_s2_a_hi;
  logic              r_s2_cy;

  // Status pulses
  logic r_acc_ovf;
  logic r_op_err;

  // Combinational nets
  logic              w_rsvd;
  logic              w_issue;
  logic              w_byp;
  logic [DATA_W-1:0] w_p_hi;
  logic [DATA_W-1:0] w_p_lo;
  logic [DATA_W:0]   w_lo_sum;
  logic [DATA_W:0]   w_lo_dif;
  logic [DATA_W-1:0] w_s1_lo;
  logic              w_s1_cy;
  logic [DATA_W-1:0] w_cy_ext;
  logic [DATA_W-1:0] w_s2_hi;
  logic              w_s2_ovf;
  logic              w_p_sgn;
  logic              w_a_sgn;
  logic              w_r_sgn;

  // Opcodes 110 and 111 are reserved; everything else enters the pipe
  assign w_rsvd  = wr_op_i[2] & wr_op_i[1];
  assign w_issue = wr_en_i & ~w_rsvd;

  // An op one cycle ahead on the same pair has not committed yet, so take
  // its result straight from stage 2 instead of the stale committed copy.
  assign w_byp  = r_s2_vld && (r_s2_idx == r_s1_idx);
  assign w_p_hi = w_byp ? w_s2_hi : r_hi[r_s1_idx];
  assign w_p_lo = w_byp ? r_s2_lo : r_lo[r_s1_idx];

  // The extra top bit carries the carry out of, or the borrow from, the low half
  assign w_lo_sum = {1'b0, w_p_lo} + {1'b0, r_s1_lo};
  assign w_lo_dif = {1'b0, w_p_lo} - {1'b0, r_s1_lo};

  // Stage 1: low-half result and carry/borrow into the high half
  always_comb begin
    w_s1_lo = '0;
    w_s1_cy = 1'b0;
    case (r_s1_op)
      OP_WR_BOTH: w_s1_lo = r_s1_lo;
      OP_WR_HI:   w_s1_lo = w_p_lo;
      OP_WR_LO:   w_s1_lo = r_s1_lo;
      OP_ACC_ADD: begin
        w_s1_lo = w_lo_sum[DATA_W-1:0];
        w_s1_cy = w_lo_sum[DATA_W];
      end
      OP_ACC_SUB: begin
        w_s1_lo = w_lo_dif[DATA_W-1:0];
        w_s1_cy = w_lo_dif[DATA_W];
      end
      default:    w_s1_lo = '0;
    endcase
  end

  assign w_cy_ext = {{(DATA_W-1){1'b0}}, r_s2_cy};

  // Stage 2: high-half result. The pair's sign bit is the top bit of the
  // high half, so signed 2W-bit overflow can be judged from the high halves.
  always_comb begin
    w_s2_hi  = '0;
    w_s2_ovf = 1'b0;
    w_p_sgn  = r_s2_p_hi[DATA_W-1];
    w_a_sgn  = r_s2_a_hi[DATA_W-1];
    case (r_s2_op)
      OP_WR_BOTH: w_s2_hi = r_s2_a_hi;
      OP_WR_HI:   w_s2_hi = r_s2_a_hi;
      OP_WR_LO:   w_s2_hi = r_s2_p_hi;
      OP_ACC_ADD: w_s2_hi = r_s2_p_hi + r_s2_a_hi + w_cy_ext;
      OP_ACC_SUB: w_s2_hi = r_s2_p_hi - r_s2_a_hi - w_cy_ext;
      default:    w_s2_hi = '0;
    endcase
    w_r_sgn = w_s2_hi[DATA_W-1];
    if (r_s2_op == OP_ACC_ADD) begin
      w_s2_ovf = (w_p_sgn == w_a_sgn) && (w_r_sgn != w_p_sgn);
    end else if (r_s2_op == OP_ACC_SUB) begin
      w_s2_ovf = (w_p_sgn != w_a_sgn) && (w_r_sgn != w_p_sgn);
    end
  end

  // Stage 1 register: capture accepted ops; reset discards anything issued alongside it
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_vld <= 1'b0;
      r_s1_op  <= '0;
      r_s1_idx <= '0;
      r_s1_hi  <= '0;
      r_s1_lo  <= '0;
    end else begin
      r_s1_vld <= w_issue;
      r_s1_op  <= wr_op_i;
      r_s1_idx <= wr_idx_i;
      r_s1_hi  <= wr_hi_i;
      r_s1_lo  <= wr_lo_i;
    end
  end

  // Stage 2 register: hand the low-half result and carry forward
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s2_vld  <= 1'b0;
      r_s2_op   <= '0;
      r_s2_idx  <= '0;
      r_s2_lo   <= '0;
      r_s2_p_hi <= '0;
      r_s2_a_hi <= '0;
      r_s2_cy   <= 1'b0;
    end else begin
      r_s2_vld  <= r_s1_vld;
      r_s2_op   <= r_s1_op;
      r_s2_idx  <= r_s1_idx;
      r_s2_lo   <= w_s1_lo;
      r_s2_p_hi <= w_p_hi;
      r_s2_a_hi <= r_s1_hi;
      r_s2_cy   <= w_s1_cy;
    end
  end

  // Commit the finished stage-2 result; reset wins, so in-flight ops are lost
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PAIRS; i++) begin
        r_hi[i] <= '0;
        r_lo[i] <= '0;
      end
    end else if (r_s2_vld) begin
      r_hi[r_s2_idx] <= w_s2_hi;
      r_lo[r_s2_idx] <= r_s2_lo;
    end
  end

  // Single-cycle status pulses: overflow at commit, error on a reserved issue
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc_ovf <= 1'b0;
      r_op_err  <= 1'b0;
    end else begin
      r_acc_ovf <= r_s2_vld & w_s2_ovf;
      r_op_err  <= wr_en_i & w_rsvd;
    end
  end

  assign hi_o         = r_hi[rd_idx_i];
  assign lo_o         = r_lo[rd_idx_i];
  assign rd_pending_o = (r_s1_vld && (r_s1_idx == rd_idx_i)) ||
                        (r_s2_vld && (r_s2_idx == rd_idx_i));
  assign acc_ovf_o    = r_acc_ovf;
  assign op_err_o     = r_op_err;

endmodule

// File: doc/hilo_bank.md
# hilo_bank

Parametrised bank of HI/LO register pairs for the execute/write-back path, the successor to the single HI/LO pair. It generalises data width and pair count. It adds per-half writes, clear, and 2W-bit multiply-accumulate/subtract (MADD/MSUB style) through a fixed two-stage commit pipeline. It also provides a pending flag so the decode/hazard logic can stall MFHI/MFLO reads behind in-flight writes.

## Interface
- DATA_W, 32, width of each HI and LO half
- PAIRS, 4, number of HI/LO pairs; power of two, ≥2
- IDX_W, 2, pair index width; must equal log2(PAIRS)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the next rising edge)
- wr_en_i  in  1  issue an operation this cycle
- wr_op_i  in  3  000 WR_BOTH, 001 WR_HI, 010 WR_LO, 011 ACC_ADD, 100 ACC_SUB, 101 CLEAR, 110/111 reserved
- wr_idx_i  in  IDX_W  target pair
- wr_hi_i  in  DATA_W  HI operand / upper half of addend
- wr_lo_i  in  DATA_W  LO operand / lower half of addend
- rd_idx_i  in  IDX_W  read pair select
- hi_o  out  DATA_W  committed HI of pair rd_idx_i, combinational
- lo_o  out  DATA_W  committed LO of pair rd_idx_i, combinational
- rd_pending_o  out  1  an in-flight op in S1 or S2 targets rd_idx_i
- acc_ovf_o  out  1  registered one-cycle pulse: ACC op committed with signed 2W-bit overflow
- op_err_o  out  1  registered one-cycle pulse: reserved op issued

## Operation
- State: PAIRS × {HI, LO}, plus pipeline registers S1 and S2 (valid, op, idx, operands).
- No back-pressure. One op is accepted per cycle whenever wr_en_i=1 and the op is non-reserved.
- Reserved op:
  - Not entered into S1.
  - op_err_o pulses the cycle after issue.
  - State is unchanged.
- S1 (cycle after issue):
  - Reads the old pair value {HI,LO} of idx.
  - If S2 is valid with the same idx, it uses S2's result (bypass), so back-to-back ops to one pair chain correctly.
  - Computes the low-half result and the carry/borrow into the high half.
- S2 (following cycle):
  - Computes the high half.
  - Commits at the end of the cycle.
- Results by op (A = {wr_hi_i, wr_lo_i}, P = old pair value):
  - WR_BOTH: {hi, lo} = A.
  - WR_HI: hi = wr_hi_i, lo kept.
  - WR_LO: lo = wr_lo_i, hi kept.
  - ACC_ADD: P + A, mod 2^(2·DATA_W).
  - ACC_SUB: P − A, mod 2^(2·DATA_W).
  - CLEAR: both halves 0.
- Overflow:
  - Evaluated as signed 2W-bit overflow for ACC_ADD and ACC_SUB only.
  - The result still wraps.
  - acc_ovf_o pulses in the cycle after commit.
- Ops to different pairs are independent. Commit order always equals issue order.
- Reads:
  - hi_o/lo_o show committed state only; in-flight values are never visible.
  - rd_pending_o = (S1.valid && S1.idx==rd_idx_i) || (S2.valid && S2.idx==rd_idx_i).
- Reset:
  - All pairs = 0; S1/S2 valid = 0.
  - acc_ovf_o = 0, op_err_o = 0, rd_pending_o = 0.
  - hi_o/lo_o = 0.
  - A reset asserted mid-operation flushes both stages; in-flight ops never commit.
  - An op issued in a reset cycle is discarded.

## Timing
- Issue at edge E0 (wr_en_i sampled), S1 busy after E0, S2 busy after E1, commit at E2.
- hi_o/lo_o reflect the new value from the cycle after E2; latency 2 for every op type.
- rd_pending_o is high for the idx during the two cycles after E0 and low once the commit is visible (if no younger op targets that idx).
- Same-idx ops issued on consecutive cycles: the second sees the first's result through the S2→S1 bypass; no bubble.
- Same-idx ops issued two cycles apart: the second's S1 reads committed state; the write and read happen at the same edge, so no bypass is needed.
- acc_ovf_o/op_err_o: high for exactly one cycle, never sticky.
- Release of reset: the first op can issue at the first edge with rst=1.

## Test plan
- Reset then WR_BOTH idx2, hi=0x12345678, lo=0x9ABCDEF0.
  - Expect hi_o/lo_o (rd_idx 2) = 0 for 2 cycles, then the written values.
  - Expect rd_pending_o high exactly 2 cycles; other pairs stay 0.
- Pair0 = {0x00000000, 0xFFFFFFFF}, then ACC_ADD {0, 1}.
  - Expect {0x00000001, 0x00000000} (carry across halves).
  - Then ACC_SUB {0, 1} → {0x00000000, 0xFFFFFFFF}.
- Back-to-back on pair1 from 0: ACC_ADD {0,5}, ACC_ADD {0,7}, WR_HI 0xAAAA0000, ACC_SUB {0,2}, one per cycle.
  - Final result {0xAAAA0000, 0x0000000A}.
  - Commits occur on 4 consecutive cycles.
- Pair3 = {0x7FFFFFFF, 0xFFFFFFFF}, then ACC_ADD {0, 1}.
  - Result {0x80000000, 0x00000000}.
  - acc_ovf_o pulses once.
  - A WR_BOTH to the same pair raises no pulse.
- Issue op 3'b110.
  - op_err_o pulses one cycle; all pairs unchanged; rd_pending_o stays 0.
- ACC_ADD to pair1 (holding 0x5), then rst=0 one cycle after issue.
  - Pair1 = 0 after reset; the op never commits; acc_ovf_o stays 0; rd_pending_o = 0.
